// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN inference result path.
package cnn_pkg;

    localparam int N_CLASS = 10;
    localparam int SCORE_W = 23;
    localparam int CLASS_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } argmax_state_e;

endpackage

// File: rtl/result_argmax.sv
// Sequential argmax over one snapshot of signed class scores.
// Reports the winning class, its score and the margin to the runner-up.
module result_argmax #(
    parameter int N_CLASS = cnn_pkg::N_CLASS,
    parameter int SCORE_W = cnn_pkg::SCORE_W
) (
    input  logic                            clk_50M,
    input  logic                            reset,
    input  logic [N_CLASS*SCORE_W-1:0]      scores_in,
    input  logic                            in_valid,
    output logic                            busy,
    output logic                            out_valid,
    output logic [cnn_pkg::CLASS_W-1:0]     class_out,
    output logic [SCORE_W-1:0]              max_out,
    output logic [SCORE_W:0]                margin_out,
    output logic                            overrun
);

    localparam int CLASS_W = cnn_pkg::CLASS_W;
    localparam int CNT_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CLASS - 1);
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    typedef cnn_pkg::argmax_state_e state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [SCORE_W-1:0]  best_q, best_d;
    logic signed [SCORE_W-1:0]  second_q, second_d;
    logic [CLASS_W-1:0]         best_idx_q, best_idx_d;
    logic                       out_valid_q, out_valid_d;
    logic [CLASS_W-1:0]         class_q, class_d;
    logic [SCORE_W-1:0]         max_q, max_d;
    logic [SCORE_W:0]           margin_q, margin_d;
    logic                       overrun_q, overrun_d;

    logic signed [SCORE_W-1:0]  score_in [N_CLASS];
    logic signed [SCORE_W-1:0]  snap_q   [N_CLASS];
    logic signed [SCORE_W-1:0]  cur_score;
    logic                       capture;

    genvar gi;
    generate
        for (gi = 0; gi < N_CLASS; gi++) begin : g_unpack
            assign score_in[gi] = scores_in[gi*SCORE_W +: SCORE_W];
        end
    endgenerate

    assign capture   = (state_q == cnn_pkg::IDLE) && in_valid;
    assign cur_score = snap_q[cnt_q];

    // The scan only ever reads the snapshot, so the live bus may change freely.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CLASS; k++) begin
                snap_q[k] <= '0;
            end
        end else if (capture) begin
            snap_q <= score_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        second_d    = second_q;
        best_idx_d  = best_idx_q;
        out_valid_d = 1'b0;
        class_d     = class_q;
        max_d       = max_q;
        margin_d    = margin_q;
        overrun_d   = overrun_q;

        case (state_q)
            cnn_pkg::IDLE: begin
                if (in_valid) begin
                    state_d    = cnn_pkg::SCAN;
                    best_d     = score_in[0];
                    best_idx_d = '0;
                    second_d   = SCORE_MIN;
                    cnt_d      = CNT_W'(1);
                end
            end
            cnn_pkg::SCAN: begin
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
                // Strict greater-than keeps the lower index on ties.
                if (cur_score > best_q) begin
                    second_d   = best_q;
                    best_d     = cur_score;
                    best_idx_d = CLASS_W'(cnt_q);
                end else if (cur_score > second_q) begin
                    second_d = cur_score;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d     = cnn_pkg::IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    class_d     = best_idx_d;
                    max_d       = best_d;
                    // best >= second always, so the sign-extended difference is non-negative.
                    margin_d    = {best_d[SCORE_W-1], best_d} - {second_d[SCORE_W-1], second_d};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = cnn_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q     <= cnn_pkg::IDLE;
            cnt_q       <= '0;
            best_q      <= '0;
            second_q    <= '0;
            best_idx_q  <= '0;
            out_valid_q <= 1'b0;
            class_q     <= '0;
            max_q       <= '0;
            margin_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            second_q    <= second_d;
            best_idx_q  <= best_idx_d;
            out_valid_q <= out_valid_d;
            class_q     <= class_d;
            max_q       <= max_d;
            margin_q    <= margin_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy       = (state_q == cnn_pkg::SCAN);
    assign out_valid  = out_valid_q;
    assign class_out  = class_q;
    assign max_out    = max_q;
    assign margin_out = margin_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_result_argmax.sv
// Directed testbench for result_argmax with hand-computed expectations.
module tb_result_argmax;

    localparam int NC = 10;
    localparam int SW = 23;

    logic                 clk_50M;
    logic                 reset;
    logic [NC*SW-1:0]     scores_in;
    logic                 in_valid;
    logic                 busy;
    logic                 out_valid;
    logic [3:0]           class_out;
    logic [SW-1:0]        max_out;
    logic [SW:0]          margin_out;
    logic                 overrun;

    int checks;
    int failures;
    int sc [NC];

    result_argmax #(
        .N_CLASS(NC),
        .SCORE_W(SW)
    ) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .scores_in  (scores_in),
        .in_valid   (in_valid),
        .busy       (busy),
        .out_valid  (out_valid),
        .class_out  (class_out),
        .max_out    (max_out),
        .margin_out (margin_out),
        .overrun    (overrun)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    function automatic logic [NC*SW-1:0] pack_scores();
        logic [NC*SW-1:0] v;
        logic [31:0]      t;
        v = '0;
        for (int k = 0; k < NC; k++) begin
            t = sc[k];
            v[k*SW +: SW] = t[SW-1:0];
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    // Presents the current sc[] with a one-cycle in_valid pulse; returns just after the capture edge.
    task automatic start_scan();
        scores_in = pack_scores();
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    // Counts edges until out_valid is seen; n = 0 means the budget expired.
    task automatic wait_out(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        scores_in = '0;
        step();
        step();
        checks++;
        if ({busy, out_valid, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {busy, out_valid, overrun});
        end
        checks++;
        if (class_out !== 4'd0 || max_out !== '0 || margin_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs got class=%0d max=%0d margin=%0d want 0 0 0", class_out, max_out, margin_out);
        end
        reset = 1'b0;
        step();
        $display("reset: busy=%b out_valid=%b class=%0d", busy, out_valid, class_out);
    endtask

    task automatic test_basic();
        int n;
        sc = '{5, 1, 2, 100, 3, 4, -7, 0, 8, 9};
        start_scan();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        wait_out(n);
        checks++;
        if (n !== 9) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=9", n);
        end
        checks++;
        if (class_out !== 4'd3 || max_out !== 23'd100 || margin_out !== 24'd91) begin
            failures++;
            $display("FAIL basic_result got class=%0d max=%0d margin=%0d want 3 100 91", class_out, max_out, margin_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b want=0", busy);
        end
        $display("basic: latency=%0d class=%0d max=%0d margin=%0d", n, class_out, max_out, margin_out);
        step();
        checks++;
        if (out_valid !== 1'b0 || class_out !== 4'd3) begin
            failures++;
            $display("FAIL basic_pulse got out_valid=%b class=%0d want 0 3", out_valid, class_out);
        end
    endtask

    task automatic test_all_equal();
        int n;
        logic [SW-1:0] exp_max;
        exp_max = SW'(-5);
        for (int k = 0; k < NC; k++) sc[k] = -5;
        start_scan();
        wait_out(n);
        checks++;
        if (n !== 9 || class_out !== 4'd0 || max_out !== exp_max || margin_out !== 24'd0) begin
            failures++;
            $display("FAIL all_equal got n=%0d class=%0d max=%h margin=%0d want 9 0 %h 0", n, class_out, max_out, exp_max, margin_out);
        end
        $display("all_equal: class=%0d max=%h margin=%0d", class_out, max_out, margin_out);
    endtask

    task automatic test_extremes();
        int n;
        for (int k = 0; k < NC; k++) sc[k] = -4194304;
        sc[9] = 4194303;
        start_scan();
        wait_out(n);
        checks++;
        if (n !== 9 || class_out !== 4'd9 || max_out !== 23'd4194303 || margin_out !== 24'd8388607) begin
            failures++;
            $display("FAIL extremes got n=%0d class=%0d max=%0d margin=%0d want 9 9 4194303 8388607", n, class_out, max_out, margin_out);
        end
        $display("extremes: class=%0d max=%0d margin=%0d", class_out, max_out, margin_out);
    endtask

    task automatic test_back_to_back();
        int n;
        sc = '{5, 1, 2, 100, 3, 4, -7, 0, 8, 9};
        start_scan();
        wait_out(n);
        // Launch the next inference in the out_valid cycle.
        sc = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        start_scan();
        checks++;
        if (busy !== 1'b1 || class_out !== 4'd3) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b class=%0d want 1 3", busy, class_out);
        end
        wait_out(n);
        checks++;
        if (n !== 9 || class_out !== 4'd4 || max_out !== 23'd50 || margin_out !== 24'd40) begin
            failures++;
            $display("FAIL b2b_result got n=%0d class=%0d max=%0d margin=%0d want 9 4 50 40", n, class_out, max_out, margin_out);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overrun got=%b want=0", overrun);
        end
        $display("back_to_back: n=%0d class=%0d overrun=%b", n, class_out, overrun);
    endtask

    task automatic test_overrun();
        int n;
        int extra;
        for (int k = 0; k < NC; k++) sc[k] = 7;
        sc[9] = 9;
        start_scan();
        step();
        step();
        // Second pulse carries different scores that must not leak into the scan.
        for (int k = 0; k < NC; k++) sc[k] = 50;
        sc[2] = 1000;
        scores_in = pack_scores();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag got=%b want=1", overrun);
        end
        wait_out(n);
        checks++;
        if (n !== 6 || class_out !== 4'd9 || max_out !== 23'd9 || margin_out !== 24'd2) begin
            failures++;
            $display("FAIL overrun_result got n=%0d class=%0d max=%0d margin=%0d want 6 9 9 2", n, class_out, max_out, margin_out);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL overrun_single got extra_out_valid=%0d want=0", extra);
        end
        $display("overrun: overrun=%b class=%0d margin=%0d extra=%0d", overrun, class_out, margin_out, extra);
        sc = '{5, 1, 2, 100, 3, 4, -7, 0, 8, 9};
        start_scan();
        wait_out(n);
        checks++;
        if (overrun !== 1'b1 || class_out !== 4'd3) begin
            failures++;
            $display("FAIL overrun_sticky got overrun=%b class=%0d want 1 3", overrun, class_out);
        end
        $display("overrun_sticky: overrun=%b class=%0d", overrun, class_out);
    endtask

    task automatic test_mid_reset();
        int n;
        int seen;
        sc = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        start_scan();
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, overrun} !== 3'b000 || class_out !== 4'd0 || max_out !== '0 || margin_out !== '0) begin
            failures++;
            $display("FAIL mid_reset got busy=%b ov=%b overrun=%b class=%0d max=%0d margin=%0d want all 0",
                     busy, out_valid, overrun, class_out, max_out, margin_out);
        end
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_reset_quiet got active_cycles=%0d want=0", seen);
        end
        sc = '{5, 1, 2, 100, 3, 4, -7, 0, 8, 9};
        start_scan();
        wait_out(n);
        checks++;
        if (n !== 9 || class_out !== 4'd3 || margin_out !== 24'd91) begin
            failures++;
            $display("FAIL mid_reset_resume got n=%0d class=%0d margin=%0d want 9 3 91", n, class_out, margin_out);
        end
        $display("mid_reset: resume n=%0d class=%0d", n, class_out);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        scores_in = '0;
        test_reset();
        test_basic();
        test_all_equal();
        test_extremes();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
